// File: rtl/cache_ram_pkg.sv
// cache_ram_pkg: shared FSM type, legal latency set and byte-lane merge for the cache data RAM
package cache_ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam logic [3:0] LEGAL_LAT = 4'b0110;
  localparam int MAX_W = 1024;
  function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0] old_w,
                                                   input logic [MAX_W-1:0] new_w,
                                                   input logic [MAX_W/8-1:0] be);
    merge_bytes = old_w;
    for (int i = 0; i < MAX_W/8; i++) if (be[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/cache_ram_array.sv
// cache_ram_array: byte-enabled storage array with a registered read-old read port
module cache_ram_array #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) for (int i = 0; i < DW/8; i++) if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cache_data_ram.sv
// cache_data_ram: cache data RAM with clear sweep, 1/2-cycle reads and write-first forwarding
module cache_data_ram
  import cache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int READ_LAT = 1,
  parameter int BYPASS = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid
);
  localparam int NB = DATA_WIDTH/8;
  if (READ_LAT != int'(READ_LAT[1:0]) || !LEGAL_LAT[READ_LAT[1:0]] || DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_W) begin : g_bad_param
    $error("cache_data_ram: illegal READ_LAT or DATA_WIDTH");
  end
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, arr_waddr;
  logic ready, arr_we, acc_rd, fwd_q, rvalid1;
  logic [NB-1:0] arr_wbe, wbe_q;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata, wdata_q, rdata1;
  always_ff @(posedge clk) state <= rst ? INIT : state_n;
  always_comb state_n = (state == INIT && cnt == '1) ? READY : state;
  always_comb begin
    init_busy = state == INIT;
    ready     = state == READY;
    arr_we    = init_busy || (write_en && ready);
    arr_waddr = init_busy ? cnt : waddr;
    arr_wbe   = init_busy ? '1 : wbe;
    arr_wdata = init_busy ? INIT_VALUE : wdata;
    acc_rd    = read_en && ready;
  end
  always_ff @(posedge clk) cnt <= (rst || !init_busy) ? '0 : cnt + 1'b1;
  cache_ram_array #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_array (
    .clk(clk), .rst(rst), .we(arr_we), .waddr(arr_waddr), .wbe(arr_wbe), .wdata(arr_wdata),
    .re(acc_rd), .raddr(raddr), .rdata(arr_rdata)
  );
  // The array returns the old word on a collision; the captured write is merged on top afterwards
  always_ff @(posedge clk)
    if (rst) begin
      rvalid1 <= 1'b0;
      fwd_q   <= 1'b0;
      wbe_q   <= '0;
      wdata_q <= '0;
    end else begin
      rvalid1 <= acc_rd;
      if (acc_rd) begin
        fwd_q   <= BYPASS != 0 && write_en && raddr == waddr;
        wbe_q   <= wbe;
        wdata_q <= wdata;
      end
    end
  always_comb rdata1 = fwd_q ? DATA_WIDTH'(merge_bytes(MAX_W'(arr_rdata), MAX_W'(wdata_q), (MAX_W/8)'(wbe_q))) : arr_rdata;
  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata2;
    logic rvalid2;
    always_ff @(posedge clk)
      if (rst) begin
        rdata2  <= '0;
        rvalid2 <= 1'b0;
      end else begin
        rvalid2 <= rvalid1;
        if (rvalid1) rdata2 <= rdata1;
      end
    assign rdata  = rdata2;
    assign rvalid = rvalid2;
  end else begin : g_lat1
    assign rdata  = rdata1;
    assign rvalid = rvalid1;
  end
endmodule

// File: tb/tb_cache_data_ram.sv
// tb_cache_data_ram: three configurations (lat1/bypass, lat1/read-old, lat2/bypass) against one stimulus stream
module tb_cache_data_ram;
  localparam logic [63:0] IV = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] DB = 64'hDEADBEEFCAFEF00D;
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  be;
    logic [63:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [63:0] e1;
    logic [63:0] e0;
  } vec_t;
  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;
  logic clk = 1'b0, rst, write_en, read_en;
  logic [3:0] waddr, raddr;
  logic [7:0] wbe;
  logic [63:0] wdata;
  logic [2:0] busy, rv;
  logic [63:0] rd [3];
  int cyc = 0, errors = 0, checks = 0;
  exp_t q [3][$];
  exp_t e;
  vec_t v [16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cache_data_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LAT(1), .BYPASS(1), .INIT_VALUE(IV)) u_b1 (
    .clk(clk), .rst(rst), .init_busy(busy[0]), .write_en(write_en), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .read_en(read_en), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]));
  cache_data_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LAT(1), .BYPASS(0), .INIT_VALUE(IV)) u_b0 (
    .clk(clk), .rst(rst), .init_busy(busy[1]), .write_en(write_en), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .read_en(read_en), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]));
  cache_data_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LAT(2), .BYPASS(1), .INIT_VALUE(IV)) u_l2 (
    .clk(clk), .rst(rst), .init_busy(busy[2]), .write_en(write_en), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .read_en(read_en), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] e1, input logic [63:0] e0);
    q[0].push_back('{e1, cyc + 1});
    q[1].push_back('{e0, cyc + 1});
    q[2].push_back('{e1, cyc + 2});
  endtask
  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rdata[%0d]", tag, i), rd[i], 64'd0);
      chk($sformatf("%s_rvalid[%0d]", tag, i), 64'(rv[i]), 64'd0);
      chk($sformatf("%s_busy[%0d]", tag, i), 64'(busy[i]), 64'd1);
    end
  endtask
  task automatic count_init(input string tag);
    int n [3] = '{0, 0, 0};
    int g = 0;
    do begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (busy[i]) n[i]++;
      g++;
    end while (busy != 3'b000 && g < 40);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_busy_cycles[%0d]", tag, i), 64'(n[i]), 64'd16);
  endtask
  task automatic chk_drained(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_drained[%0d]", tag, i), 64'(q[i].size()), 64'd0);
  endtask
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (rv[i]) begin
        if (q[i].size() == 0) chk($sformatf("spurious_rvalid[%0d]", i), 64'(rv[i]), 64'd0);
        else begin
          e = q[i].pop_front();
          chk($sformatf("rdata[%0d]", i), rd[i], e.d);
          chk($sformatf("latency[%0d]", i), 64'(cyc), 64'(e.due));
        end
      end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
        e = q[i].pop_front();
        chk($sformatf("missing_rvalid[%0d]", i), 64'(rv[i]), 64'd1);
      end
  initial begin
    v[0]  = '{0, 0,  8'h00, 64'h0,                1, 2,  IV,                    IV};
    v[1]  = '{1, 5,  8'hFF, 64'h1122334455667788, 0, 0,  64'h0,                 64'h0};
    v[2]  = '{1, 5,  8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0,  64'h0,                 64'h0};
    v[3]  = '{0, 0,  8'h00, 64'h0,                1, 5,  64'h11223344AAAAAAAA,  64'h11223344AAAAAAAA};
    v[4]  = '{1, 7,  8'hFF, 64'h0,                0, 0,  64'h0,                 64'h0};
    v[5]  = '{1, 7,  8'h03, 64'hFFFFFFFFFFFFFFFF, 1, 7,  64'h000000000000FFFF,  64'h0};
    v[6]  = '{0, 0,  8'h00, 64'h0,                1, 7,  64'h000000000000FFFF,  64'h000000000000FFFF};
    v[7]  = '{1, 3,  8'hFF, DB,                   1, 3,  DB,                    IV};
    v[8]  = '{1, 3,  8'h00, 64'h0,                1, 3,  DB,                    DB};
    v[9]  = '{1, 4,  8'h80, 64'h0123456789ABCDEF, 1, 3,  DB,                    DB};
    v[10] = '{0, 0,  8'h00, 64'h0,                1, 4,  64'h01A5A5A5A5A5A5A5,  64'h01A5A5A5A5A5A5A5};
    v[11] = '{1, 15, 8'hF0, 64'hFEDCBA9876543210, 1, 0,  IV,                    IV};
    v[12] = '{0, 0,  8'h00, 64'h0,                1, 15, 64'hFEDCBA98A5A5A5A5,  64'hFEDCBA98A5A5A5A5};
    v[13] = '{0, 0,  8'h00, 64'h0,                1, 1,  IV,                    IV};
    v[14] = '{0, 0,  8'h00, 64'h0,                1, 2,  IV,                    IV};
    v[15] = '{0, 0,  8'h00, 64'h0,                1, 3,  DB,                    DB};
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; waddr = '0; raddr = '0; wbe = '0; wdata = '0;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0; write_en = 1'b1; waddr = 4'd2; wbe = 8'hFF; wdata = 64'h1234; read_en = 1'b1; raddr = 4'd2;
    count_init("init");
    write_en = 1'b0; read_en = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      write_en = v[k].we; waddr = v[k].wa; wbe = v[k].be; wdata = v[k].wd;
      read_en = v[k].re; raddr = v[k].ra;
      if (v[k].re) push(v[k].e1, v[k].e0);
      tick();
    end
    write_en = 1'b0; read_en = 1'b0;
    repeat (6) tick();
    chk_drained("table");
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hold_rdata[%0d]", i), rd[i], DB);
        chk($sformatf("hold_rvalid[%0d]", i), 64'(rv[i]), 64'd0);
      end
    end
    tick();
    read_en = 1'b1; raddr = 4'd5;
    q[0].push_back('{64'h11223344AAAAAAAA, cyc + 1});
    q[1].push_back('{64'h11223344AAAAAAAA, cyc + 1});
    tick();
    raddr = 4'd7; rst = 1'b1;
    tick();
    read_en = 1'b0;
    chk_idle("rst_inflight");
    rst = 1'b0;
    repeat (9) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("busy_mid_sweep[%0d]", i), 64'(busy[i]), 64'd1);
    rst = 1'b1;
    tick();
    chk_idle("rst_sweep");
    rst = 1'b0;
    count_init("resweep");
    tick();
    read_en = 1'b1; raddr = 4'd15; push(IV, IV);
    tick();
    raddr = 4'd5; push(IV, IV);
    tick();
    read_en = 1'b0;
    repeat (5) tick();
    chk_drained("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
